// File: rtl/seg_scan4_pkg.sv
// rtl/seg_scan4_pkg.sv - shared constants and helpers for the 4-digit seven-segment scanner
package seg_scan4_pkg;

  localparam int IDX_W = 2;

  // Active-low segment codes, bit 0 = a ... bit 6 = g
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [3:0] AN_OFF  = 4'hF;

  // True when digit idx and every digit to its left are zero; digit 0 never qualifies
  function automatic logic lzs_hit(input logic [15:0] data, input logic [IDX_W-1:0] idx);
    case (idx)
      2'd1:    return (data[15:4] == 12'h000);
      2'd2:    return (data[15:8] == 8'h00);
      2'd3:    return (data[15:12] == 4'h0);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan4_hex_to_seg7.sv
// rtl/seg_scan4_hex_to_seg7.sv - combinational hex nibble to active-low seven-segment decoder
module hex_to_seg7
  import seg_scan4_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan4.sv
// rtl/seg_scan4.sv - time-multiplexed 4-digit common-anode display driver with LZS and dead-time
module seg_scan4
  import seg_scan4_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 1000
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [15:0] iData,
  input  logic [3:0]  iDp,
  input  logic [3:0]  iBlank,
  input  logic        iLzs,
  output logic [3:0]  oAn,
  output logic [6:0]  oSeg,
  output logic        oDp
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       nib_q, nib_d;
  logic             dp_q, dp_d;
  logic             blank_q, blank_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dpo_q, dpo_d;
  logic             tick;
  logic [6:0]       dec_seg;

  // Slot snapshot: everything about the next digit is frozen at the tick
  always_comb begin
    tick    = (cnt_q == CNT_MAX);
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d   = tick ? idx_q + IDX_W'(1) : idx_q;
    nib_d   = nib_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    if (tick) begin
      nib_d   = iData[{idx_d, 2'b00} +: 4];
      dp_d    = iDp[idx_d];
      blank_d = iBlank[idx_d] | (iLzs & lzs_hit(iData, idx_d));
    end
  end

  hex_to_seg7 u_dec (
    .hex (nib_d),
    .seg (dec_seg)
  );

  // Outputs are computed from next-state values so they change on the same edge as the slot
  always_comb begin
    seg_d = blank_d ? SEG_OFF : dec_seg;
    dpo_d = blank_d | ~dp_d;
    an_d  = AN_OFF;
    if (!blank_d && (cnt_d >= GUARD_C)) begin
      an_d[idx_d] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= IDX_W'(3);
      nib_q   <= 4'h0;
      dp_q    <= 1'b0;
      blank_q <= 1'b1;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dpo_q   <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      nib_q   <= nib_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
    end
  end

  assign oAn  = an_q;
  assign oSeg = seg_q;
  assign oDp  = dpo_q;

endmodule

// File: doc/seg_scan4.md
Name: seg_scan4

Overview:
- Downstream display stage for the counter/timer blocks: takes four 4-bit hex values and drives a time-multiplexed 4-digit common-anode seven-segment display.
- Contains a scan prescaler, a digit rotation counter, per-slot data snapshot, leading-zero suppression, and anti-ghosting dead-time.
- Sits between the counter outputs (oQ-style values, zero-extended to nibbles) and the board anode/segment pins.

Parameters:
- SCAN_DIV, 100000, CLK cycles per digit slot (1 kHz per digit at 100 MHz); must be >= 2.
- GUARD, 1000, cycles at the start of each slot with all anodes off; must satisfy 0 <= GUARD < SCAN_DIV.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
- iData  input  16  four hex digits; iData[4k+3:4k] is digit k, digit 0 is rightmost.
- iDp  input  4  decimal-point request per digit, active-high.
- iBlank  input  4  force digit k dark, active-high.
- iLzs  input  1  leading-zero suppression enable.
- oAn  output  4  anode select, active-low, at most one bit low.
- oSeg  output  7  segments, active-low; oSeg[0]=a … oSeg[6]=g.
- oDp  output  1  decimal point, active-low.

Behaviour:
- Reset: rst_n low at a CLK edge gives cnt=0, idx=3, oAn=4'hF, oSeg=7'h7F, oDp=1. Reset wins over every other event, including mid-slot.
- Prescaler cnt counts 0..SCAN_DIV-1 and wraps. The tick condition is cnt==SCAN_DIV-1.
- On a tick, idx advances modulo 4 (3→0). The first tick after reset therefore selects digit 0.
- Snapshot: on the tick, capture the new digit's nibble, dp bit and blank decision into slot registers. Input changes mid-slot have no effect until the next tick.
- Leading-zero suppression: digit k≥1 is blanked if iLzs=1 and nibbles k..3 of iData are all zero, evaluated on the tick snapshot. Digit 0 is never suppressed.
- A blanked digit (iBlank[k] or LZS) keeps oAn=4'hF for the whole slot, with oSeg=7'h7F and oDp=1.
- Slot timing: a slot begins the cycle after the tick.
  - First GUARD cycles: oAn=4'hF.
  - Remaining SCAN_DIV-GUARD cycles: oAn[idx]=0 and the other bits are 1.
  - oSeg/oDp take the new digit value in the first slot cycle, i.e. while anodes are off.
- All outputs are registered. No combinational path from inputs to outputs.
- Decode (active-low, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- oDp = ~dp for non-blanked digits.
- Full scan period = 4*SCAN_DIV cycles.
- Power-up before the first reset is undefined; a reset is required.

Decomposition:
- Shared package holds:
  - segment-code constants SEG_0..SEG_F and SEG_OFF=7'h7F;
  - AN_OFF=4'hF;
  - digit index width localparam (2).
- One sub-module: hex_to_seg7, a combinational 4-bit to 7-bit active-low decoder instantiated once on the slot nibble.
- Scan counter and snapshot logic stay in seg_scan4.

Test Plan:
1. Reset/first slot: SCAN_DIV=8, GUARD=2, rst_n low 3 cycles then high, iData=16'h1234.
   - First 8 cycles: oAn=F, oSeg=7F, oDp=1.
   - Then digit 0 slot: 2 cycles oAn=F with oSeg=19 ("4"), then 6 cycles oAn=E with oSeg=19.
2. Rotation: continue scenario 1 for 4 slots.
   - oAn low phases in order E, D, B, 7 with oSeg 19, 30, 24, 79.
   - Pattern wraps back to E on the 5th slot.
3. LZS: iData=16'h0050, iLzs=1.
   - Digits 3 and 2 fully dark (oAn=F for whole slot).
   - Digit 1 shows 12; digit 0 shows 40.
   - With iData=0000, only digit 0 lights (40).
4. Snapshot/blank/dp: change iData mid-slot of digit 1 from 1234 to 1294.
   - Displayed value stays 30 until the next digit-1 slot, which shows 10.
   - iBlank=4'b0100 keeps digit 2 dark.
   - iDp=4'b0001 gives oDp=0 only during the digit-0 slot.
5. Mid-slot reset: assert rst_n low during the active phase of digit 2.
   - Next cycle: oAn=F, oSeg=7F, oDp=1.
   - After release, the scan restarts and the first lit digit is digit 0 after SCAN_DIV+GUARD cycles.
